switch_mcu_regfile: RTL and testbench
=====================================

Name: switch_mcu_regfile

Overview:
- General-purpose register file for the switch MCU core.
- Sits directly downstream of the execute units, e.g. the R-type ALU stage. It serves their two registered read requests and their single write-back request.
- Provides 32 x 32-bit architectural registers. x0 is hardwired to zero.
- Read data is registered: it is returned one clock after the read enable is sampled, then held until the next read.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width
DEPTH, 32, number of registers (must equal 2**ADDR_W)

Ports:
in_clk  input  1  clock, rising edge
in_rst  input  1  asynchronous reset, active low
in_ren_1  input  1  read request, port 1
in_raddr_1  input  ADDR_W  read address, port 1
out_rdata_1  output  DATA_W  registered read data, port 1
in_ren_2  input  1  read request, port 2
in_raddr_2  input  ADDR_W  read address, port 2
out_rdata_2  output  DATA_W  registered read data, port 2
in_wen  input  1  write request
in_waddr  input  ADDR_W  write address
in_wdata  input  DATA_W  write data
in_dbg_raddr  input  ADDR_W  debug/verification peek address
out_dbg_rdata  output  DATA_W  combinational peek of storage array

Behaviour:
- Reset (in_rst low, asynchronous):
  - All DEPTH storage entries cleared to 0.
  - out_rdata_1 and out_rdata_2 cleared to 0.
  - Reset takes effect immediately, including mid-write or mid-read. A write sampled on the edge coincident with reset assertion is discarded.
- Write:
  - On a rising edge with in_wen=1 and in_waddr!=0: mem[in_waddr] <= in_wdata.
  - Writes to address 0 are silently dropped; mem[0] stays 0 permanently.
- Read, each port independently:
  - On a rising edge with in_ren_n=1: out_rdata_n <= mem[in_raddr_n], or 0 if in_raddr_n==0.
  - With in_ren_n=0: out_rdata_n holds its previous value. The upstream stage samples the data one or more cycles after the request.
- Latency:
  - Request sampled at edge N, data visible after edge N.
  - For the 4-cycle execute sequence, the request is driven in cycle 2. Data is stable in cycle 3 and consumed at the cycle-4 edge.
- Both ports may read the same address in the same cycle; both return the same value.
- Read-during-write to the same non-zero address on the same edge: see Optional Feature. Default (macro absent): the old value is returned.
- Write and read to different addresses on the same edge do not interact.
- out_dbg_rdata = mem[in_dbg_raddr], combinational, no bypass. Reads 0 for address 0.
- Address width equals index width, so there is no out-of-range case.
- No handshake back-pressure: every request completes in one edge.

Optional Feature:
- Macro: SWITCH_MCU_RF_BYPASS_EN.
- When defined: if in_ren_n=1, in_wen=1, in_raddr_n==in_waddr and in_waddr!=0 on the same edge, out_rdata_n <= in_wdata (new value forwarded). Applies to both ports independently.
- When undefined: the same case returns the pre-write contents of mem.
- Writes to x0 are never forwarded in either build.

Test Plan:
- Reset, then ren_1=1 raddr_1=5 and ren_2=1 raddr_2=31 -> next cycle out_rdata_1=0, out_rdata_2=0; dbg peek of every address =0.
- Write x3=0x1234_5678. Next cycle ren_1=1 raddr_1=3, then drop ren_1 for 3 cycles -> out_rdata_1=0x1234_5678 after the read edge and held for all 3 idle cycles.
- Write x0=0xFFFF_FFFF, then read port 2 addr 0 -> out_rdata_2=0; dbg peek addr 0 =0.
- x7 preloaded 0xA; same edge wen=1 waddr=7 wdata=0xB with ren_1=ren_2=1 raddr=7 -> out_rdata_1/2 =0xA without macro, 0xB with SWITCH_MCU_RF_BYPASS_EN; following read returns 0xB in both builds.
- Back-to-back R-type sequence: x1=5 and x2=3 preloaded; read 1,2 -> rdata 5,3; write x4=8 -> dbg peek addr 4 =8.
- Assert in_rst mid-sequence while wen=1 waddr=9 wdata=0x55 -> x9 reads 0 after reset release; both rdata outputs 0 immediately on reset assertion.

Source files
------------

// File: rtl/switch_mcu_regfile_if.sv
// switch_mcu_regfile_if: read/write/debug bus between execute units and the register file
interface switch_mcu_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              in_ren_1;
    logic [ADDR_W-1:0] in_raddr_1;
    logic [DATA_W-1:0] out_rdata_1;
    logic              in_ren_2;
    logic [ADDR_W-1:0] in_raddr_2;
    logic [DATA_W-1:0] out_rdata_2;
    logic              in_wen;
    logic [ADDR_W-1:0] in_waddr;
    logic [DATA_W-1:0] in_wdata;
    logic [ADDR_W-1:0] in_dbg_raddr;
    logic [DATA_W-1:0] out_dbg_rdata;

    modport master (
        output in_ren_1, in_raddr_1, in_ren_2, in_raddr_2,
        output in_wen, in_waddr, in_wdata, in_dbg_raddr,
        input  out_rdata_1, out_rdata_2, out_dbg_rdata
    );

    modport slave (
        input  in_ren_1, in_raddr_1, in_ren_2, in_raddr_2,
        input  in_wen, in_waddr, in_wdata, in_dbg_raddr,
        output out_rdata_1, out_rdata_2, out_dbg_rdata
    );
endinterface

// File: rtl/switch_mcu_regfile.sv
// switch_mcu_regfile: 32x32 register file, x0 hardwired to zero, two registered read ports, one write port
// Optional macro SWITCH_MCU_RF_BYPASS_EN forwards same-edge write data to a matching read port.
module switch_mcu_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input logic in_clk,
    input logic in_rst,
    switch_mcu_regfile_if.slave bus
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_1_q, rdata_1_d;
    logic [DATA_W-1:0] rdata_2_q, rdata_2_d;
    logic              wr_en;
    logic              fwd_1, fwd_2;

    assign wr_en = bus.in_wen && (bus.in_waddr != '0);

`ifdef SWITCH_MCU_RF_BYPASS_EN
    assign fwd_1 = wr_en && (bus.in_waddr == bus.in_raddr_1);
    assign fwd_2 = wr_en && (bus.in_waddr == bus.in_raddr_2);
`else
    assign fwd_1 = 1'b0;
    assign fwd_2 = 1'b0;
`endif

    // Next read data: hold unless requested; x0 reads zero, optional forwarding of write data
    always_comb begin
        rdata_1_d = rdata_1_q;
        rdata_2_d = rdata_2_q;
        if (bus.in_ren_1)
            rdata_1_d = fwd_1 ? bus.in_wdata : (bus.in_raddr_1 == '0) ? '0 : mem_q[bus.in_raddr_1];
        if (bus.in_ren_2)
            rdata_2_d = fwd_2 ? bus.in_wdata : (bus.in_raddr_2 == '0) ? '0 : mem_q[bus.in_raddr_2];
    end

    // Storage array: cleared on reset, x0 never written
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[bus.in_waddr] <= bus.in_wdata;
        end
    end

    // Registered read data for both ports
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            rdata_1_q <= '0;
            rdata_2_q <= '0;
        end else begin
            rdata_1_q <= rdata_1_d;
            rdata_2_q <= rdata_2_d;
        end
    end

    assign bus.out_rdata_1   = rdata_1_q;
    assign bus.out_rdata_2   = rdata_2_q;
    assign bus.out_dbg_rdata = (bus.in_dbg_raddr == '0) ? '0 : mem_q[bus.in_dbg_raddr];
endmodule

// File: tb/tb_switch_mcu_regfile.sv
// tb_switch_mcu_regfile: directed and randomized checks of the register file against an array model
module tb_switch_mcu_regfile;
`ifdef SWITCH_MCU_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic in_clk = 1'b0;
    logic in_rst = 1'b0;
    int total = 0;
    int bad = 0;
    logic [31:0] model [32];
    logic [31:0] exp1, exp2;

    switch_mcu_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    switch_mcu_regfile dut (.in_clk(in_clk), .in_rst(in_rst), .bus(bus));

    always #5 in_clk = ~in_clk;

    task automatic idle();
        bus.in_ren_1 = 0; bus.in_raddr_1 = 0;
        bus.in_ren_2 = 0; bus.in_raddr_2 = 0;
        bus.in_wen = 0; bus.in_waddr = 0; bus.in_wdata = 0;
    endtask

    // Reference: register semantics applied to the inputs present at the coming edge
    task automatic cycle();
        if (bus.in_ren_1)
            exp1 = (BYP && bus.in_wen && bus.in_waddr != 0 && bus.in_waddr == bus.in_raddr_1) ? bus.in_wdata : model[bus.in_raddr_1];
        if (bus.in_ren_2)
            exp2 = (BYP && bus.in_wen && bus.in_waddr != 0 && bus.in_waddr == bus.in_raddr_2) ? bus.in_wdata : model[bus.in_raddr_2];
        if (bus.in_wen && bus.in_waddr != 0) model[bus.in_waddr] = bus.in_wdata;
        @(posedge in_clk); #1;
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d);
        idle(); bus.in_wen = 1; bus.in_waddr = a; bus.in_wdata = d;
        cycle(); idle();
    endtask

    task automatic test_reset();
        idle(); bus.in_dbg_raddr = 0;
        for (int i = 0; i < 32; i++) model[i] = 0;
        exp1 = 0; exp2 = 0;
        repeat (2) @(posedge in_clk);
        #1;
        total++; if (bus.out_rdata_1 !== 32'h0 || bus.out_rdata_2 !== 32'h0) begin
            bad++; $display("FAIL reset_out: rdata_1=%h rdata_2=%h expected 0", bus.out_rdata_1, bus.out_rdata_2);
        end
        @(negedge in_clk); in_rst = 1;
        bus.in_ren_1 = 1; bus.in_raddr_1 = 5; bus.in_ren_2 = 1; bus.in_raddr_2 = 31;
        cycle(); idle();
        total++; if (bus.out_rdata_1 !== 32'h0 || bus.out_rdata_2 !== 32'h0) begin
            bad++; $display("FAIL reset_read: rdata_1=%h rdata_2=%h expected 0", bus.out_rdata_1, bus.out_rdata_2);
        end
        for (int i = 0; i < 32; i++) begin
            bus.in_dbg_raddr = i[4:0]; #1;
            total++; if (bus.out_dbg_rdata !== 32'h0) begin
                bad++; $display("FAIL reset_dbg[%0d]: got %h expected 0", i, bus.out_dbg_rdata);
            end
        end
    endtask

    task automatic test_hold();
        write(3, 32'h1234_5678);
        bus.in_ren_1 = 1; bus.in_raddr_1 = 3;
        cycle();
        total++; if (bus.out_rdata_1 !== 32'h1234_5678) begin
            bad++; $display("FAIL hold_read: rdata_1=%h expected 12345678", bus.out_rdata_1);
        end
        idle(); bus.in_raddr_1 = 9;
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++; if (bus.out_rdata_1 !== 32'h1234_5678) begin
                bad++; $display("FAIL hold_idle%0d: rdata_1=%h expected 12345678", i, bus.out_rdata_1);
            end
        end
    endtask

    task automatic test_x0();
        idle(); bus.in_wen = 1; bus.in_waddr = 0; bus.in_wdata = 32'hFFFF_FFFF;
        bus.in_ren_2 = 1; bus.in_raddr_2 = 3;
        cycle();
        total++; if (bus.out_rdata_2 !== 32'h1234_5678) begin
            bad++; $display("FAIL x0_pre: rdata_2=%h expected 12345678", bus.out_rdata_2);
        end
        idle(); bus.in_ren_2 = 1; bus.in_raddr_2 = 0;
        cycle(); idle();
        total++; if (bus.out_rdata_2 !== 32'h0) begin
            bad++; $display("FAIL x0_read: rdata_2=%h expected 0", bus.out_rdata_2);
        end
        bus.in_dbg_raddr = 0; #1;
        total++; if (bus.out_dbg_rdata !== 32'h0) begin
            bad++; $display("FAIL x0_dbg: got %h expected 0", bus.out_dbg_rdata);
        end
    endtask

    task automatic test_rdw();
        logic [31:0] want;
        want = BYP ? 32'hB : 32'hA;
        write(7, 32'hA);
        bus.in_wen = 1; bus.in_waddr = 7; bus.in_wdata = 32'hB;
        bus.in_ren_1 = 1; bus.in_raddr_1 = 7; bus.in_ren_2 = 1; bus.in_raddr_2 = 7;
        cycle(); idle();
        total++; if (bus.out_rdata_1 !== want || bus.out_rdata_2 !== want) begin
            bad++; $display("FAIL rdw_same_edge: rdata_1=%h rdata_2=%h expected %h", bus.out_rdata_1, bus.out_rdata_2, want);
        end
        bus.in_ren_1 = 1; bus.in_raddr_1 = 7; bus.in_ren_2 = 1; bus.in_raddr_2 = 7;
        cycle(); idle();
        total++; if (bus.out_rdata_1 !== 32'hB || bus.out_rdata_2 !== 32'hB) begin
            bad++; $display("FAIL rdw_after: rdata_1=%h rdata_2=%h expected 0000000b", bus.out_rdata_1, bus.out_rdata_2);
        end
    endtask

    task automatic test_back_to_back();
        write(1, 32'd5);
        write(2, 32'd3);
        bus.in_ren_1 = 1; bus.in_raddr_1 = 1; bus.in_ren_2 = 1; bus.in_raddr_2 = 2;
        cycle(); idle();
        total++; if (bus.out_rdata_1 !== 32'd5 || bus.out_rdata_2 !== 32'd3) begin
            bad++; $display("FAIL b2b_read: rdata_1=%h rdata_2=%h expected 5,3", bus.out_rdata_1, bus.out_rdata_2);
        end
        write(4, 32'd8);
        bus.in_dbg_raddr = 4; #1;
        total++; if (bus.out_dbg_rdata !== 32'd8) begin
            bad++; $display("FAIL b2b_dbg: got %h expected 8", bus.out_dbg_rdata);
        end
        total++; if (bus.out_rdata_1 !== 32'd5 || bus.out_rdata_2 !== 32'd3) begin
            bad++; $display("FAIL b2b_hold: rdata_1=%h rdata_2=%h expected 5,3", bus.out_rdata_1, bus.out_rdata_2);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bus.in_ren_1 = 1'($urandom_range(0, 1));
            bus.in_ren_2 = 1'($urandom_range(0, 1));
            bus.in_wen = 1'($urandom_range(0, 1));
            bus.in_raddr_1 = 5'($urandom_range(0, 7));
            bus.in_raddr_2 = 5'($urandom_range(0, 7));
            bus.in_waddr = (n % 4 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            bus.in_wdata = $urandom;
            bus.in_dbg_raddr = 5'($urandom_range(0, 31));
            cycle();
            total++; if (bus.out_rdata_1 !== exp1 || bus.out_rdata_2 !== exp2) begin
                bad++; $display("FAIL random_read[%0d]: rdata_1=%h rdata_2=%h expected %h,%h", n, bus.out_rdata_1, bus.out_rdata_2, exp1, exp2);
            end
            total++; if (bus.out_dbg_rdata !== model[bus.in_dbg_raddr]) begin
                bad++; $display("FAIL random_dbg[%0d]: addr=%0d got %h expected %h", n, bus.in_dbg_raddr, bus.out_dbg_rdata, model[bus.in_dbg_raddr]);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        write(9, 32'h77);
        bus.in_ren_1 = 1; bus.in_raddr_1 = 9; bus.in_ren_2 = 1; bus.in_raddr_2 = 9;
        cycle(); idle();
        total++; if (bus.out_rdata_1 !== 32'h77 || bus.out_rdata_2 !== 32'h77) begin
            bad++; $display("FAIL mid_pre: rdata_1=%h rdata_2=%h expected 77", bus.out_rdata_1, bus.out_rdata_2);
        end
        bus.in_wen = 1; bus.in_waddr = 9; bus.in_wdata = 32'h55;
        #2 in_rst = 0;
        #1;
        total++; if (bus.out_rdata_1 !== 32'h0 || bus.out_rdata_2 !== 32'h0) begin
            bad++; $display("FAIL mid_async: rdata_1=%h rdata_2=%h expected 0", bus.out_rdata_1, bus.out_rdata_2);
        end
        @(posedge in_clk);
        @(negedge in_clk); in_rst = 1;
        for (int i = 0; i < 32; i++) model[i] = 0;
        exp1 = 0; exp2 = 0;
        idle();
        bus.in_dbg_raddr = 9; #1;
        total++; if (bus.out_dbg_rdata !== 32'h0) begin
            bad++; $display("FAIL mid_dbg: got %h expected 0", bus.out_dbg_rdata);
        end
        bus.in_ren_1 = 1; bus.in_raddr_1 = 9;
        cycle(); idle();
        total++; if (bus.out_rdata_1 !== 32'h0) begin
            bad++; $display("FAIL mid_read: rdata_1=%h expected 0", bus.out_rdata_1);
        end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_x0();
        test_rdw();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
